// File: rtl/geig_pulse_detect.sv
// geig_pulse_detect -- synchronises a raw geiger tube pulse stream, debounces
// it into one-cycle events, blanks the tube dead time, and keeps a saturating
// per-window event count that is latched and cleared by CNT_CLR.
// Optional stuck-tube flag: define GEIG_STUCK_DETECT_EN to build it.
module geig_pulse_detect #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 48,
    parameter int DEADTIME_CYCLES = 4800,
    parameter int STUCK_CYCLES    = 480000
) (
    input  logic       CLK_48MHZ,
    input  logic       RESET_N,
    input  logic       GSTREAM,
    input  logic       CNT_CLR,
    output logic       GEIG_EVENT,
    output logic [7:0] GEIG_COUNT,
    output logic [7:0] GEIG_COUNT_LATCHED,
    output logic       COUNT_VALID,
    output logic       GEIG_STUCK,
    output logic [1:0] DBG_STATE
);

    localparam int QW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DW = (DEADTIME_CYCLES > 1) ? $clog2(DEADTIME_CYCLES) : 1;
    localparam logic [QW-1:0] QUAL_MAX  = QW'(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DEAD_LAST = DW'(DEADTIME_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUALIFY = 2'd1,
        HOLD    = 2'd2,
        DEAD    = 2'd3
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   gs;
    logic                   armed;
    logic [QW-1:0]          qual_cnt;
    logic [DW-1:0]          dead_cnt;

    assign gs        = sync_q[SYNC_STAGES-1];
    assign DBG_STATE = state;

    // Synchroniser chain, plus an arming flag: after reset the input must be
    // seen low (once the chain holds real samples) before a pulse can
    // qualify, so a pulse cut in half by reset is never counted again.
    always_ff @(posedge CLK_48MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_q <= '0;
            fill_q <= '0;
            armed  <= 1'b0;
        end else begin
            sync_q <= (sync_q << 1) | SYNC_STAGES'(GSTREAM);
            fill_q <= (fill_q << 1) | SYNC_STAGES'(1'b1);
            armed  <= armed | (fill_q[SYNC_STAGES-1] & ~gs);
        end
    end

    // Pulse FSM: qualify a high run, emit one event, wait for the fall, then
    // blank for the dead time regardless of the input.
    always_ff @(posedge CLK_48MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= IDLE;
            qual_cnt   <= '0;
            dead_cnt   <= '0;
            GEIG_EVENT <= 1'b0;
        end else begin
            GEIG_EVENT <= 1'b0;
            case (state)
                IDLE: begin
                    if (gs && armed) begin
                        state    <= QUALIFY;
                        qual_cnt <= QW'(1);
                    end
                end
                QUALIFY: begin
                    if (!gs) begin
                        state    <= IDLE;
                        qual_cnt <= '0;
                    end else if (qual_cnt == QUAL_MAX) begin
                        state      <= HOLD;
                        qual_cnt   <= '0;
                        GEIG_EVENT <= 1'b1;
                    end else begin
                        qual_cnt <= qual_cnt + QW'(1);
                    end
                end
                HOLD: begin
                    if (!gs) begin
                        state    <= DEAD;
                        dead_cnt <= '0;
                    end
                end
                DEAD: begin
                    if (dead_cnt == DEAD_LAST) begin
                        state    <= IDLE;
                        dead_cnt <= '0;
                    end else begin
                        dead_cnt <= dead_cnt + DW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Window counter. COUNT_VALID is a valid-only strobe with no ready: it is
    // high for exactly one cycle after each CNT_CLR cycle and the consumer
    // must take GEIG_COUNT_LATCHED in that cycle. An event coinciding with a
    // clear belongs to the new window.
    always_ff @(posedge CLK_48MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            GEIG_COUNT         <= 8'd0;
            GEIG_COUNT_LATCHED <= 8'd0;
            COUNT_VALID        <= 1'b0;
        end else begin
            COUNT_VALID <= CNT_CLR;
            if (CNT_CLR) begin
                GEIG_COUNT_LATCHED <= GEIG_COUNT;
                GEIG_COUNT         <= {7'd0, GEIG_EVENT};
            end else if (GEIG_EVENT && (GEIG_COUNT != 8'hFF)) begin
                GEIG_COUNT <= GEIG_COUNT + 8'd1;
            end
        end
    end

`ifdef GEIG_STUCK_DETECT_EN
    localparam int SW = (STUCK_CYCLES > 1) ? $clog2(STUCK_CYCLES) : 1;
    localparam logic [SW-1:0] STUCK_LAST = SW'(STUCK_CYCLES - 1);

    logic [SW-1:0] stuck_cnt;

    // Stuck-tube timer: runs while held high in HOLD, flag drops on the edge
    // the FSM leaves HOLD.
    always_ff @(posedge CLK_48MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            stuck_cnt  <= '0;
            GEIG_STUCK <= 1'b0;
        end else if (state == HOLD && gs) begin
            if (stuck_cnt == STUCK_LAST) begin
                GEIG_STUCK <= 1'b1;
            end else begin
                stuck_cnt <= stuck_cnt + SW'(1);
            end
        end else begin
            stuck_cnt  <= '0;
            GEIG_STUCK <= 1'b0;
        end
    end
`else
    // Constant low; the comparison only keeps the parameter referenced here.
    assign GEIG_STUCK = (STUCK_CYCLES < 0);
`endif

endmodule

// File: doc/geig_pulse_detect.md
GEIG_PULSE_DETECT -- requirements
Module: geig_pulse_detect

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, meaning the number of flops synchronising GSTREAM.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 48, meaning the consecutive high samples (1 us) needed to qualify a pulse.
REQ-003 The block SHALL have parameter DEADTIME_CYCLES, default 4800, meaning the post-pulse blanking (100 us) after GSTREAM falls.
REQ-004 The block SHALL have parameter STUCK_CYCLES, default 480000, meaning the continuous-high hold (10 ms) that flags a stuck tube.
REQ-005 The block SHALL have port CLK_48MHZ  in  1  system clock, all logic on its rising edge.
REQ-006 The block SHALL have port RESET_N  in  1  asynchronous active-low reset.
REQ-007 The block SHALL have port GSTREAM  in  1  raw asynchronous geiger pulse input, active high.
REQ-008 The block SHALL have port CNT_CLR  in  1  synchronous one-cycle window-end strobe.
REQ-009 The block SHALL have port GEIG_EVENT  out  1  one-cycle strobe per qualified pulse.
REQ-010 The block SHALL have port GEIG_COUNT  out  8  running saturating event count for the current window.
REQ-011 The block SHALL have port GEIG_COUNT_LATCHED  out  8  count captured at the last CNT_CLR.
REQ-012 The block SHALL have port COUNT_VALID  out  1  one-cycle strobe marking GEIG_COUNT_LATCHED updated.
REQ-013 The block SHALL have port GEIG_STUCK  out  1  level flag, input held high too long.

Function
REQ-014 The block SHALL pass GSTREAM through SYNC_STAGES flops; every later reference to the input is to the synchronised signal (gs).
REQ-015 The block SHALL implement FSM states IDLE, QUALIFY, HOLD and DEAD.
REQ-016 In IDLE, gs=1 SHALL move the FSM to QUALIFY with the qualify counter set to 1.
REQ-017 In QUALIFY, gs=0 SHALL return the FSM to IDLE with no event, as a rejected glitch.
REQ-018 In QUALIFY, gs=1 SHALL increment the qualify counter; when it reaches DEBOUNCE_CYCLES the FSM SHALL enter HOLD and pulse GEIG_EVENT for exactly 1 cycle.
REQ-019 With default parameters, a clean pulse SHALL produce GEIG_EVENT exactly SYNC_STAGES+DEBOUNCE_CYCLES+1 = 51 clock edges after the first edge that samples GSTREAM high.
REQ-020 In HOLD, gs=0 SHALL move the FSM to DEAD; a held-high input SHALL yield exactly one event however long it is held.
REQ-021 DEAD SHALL last DEADTIME_CYCLES cycles regardless of gs, then return to IDLE; a pulse arriving during DEAD SHALL be ignored, or SHALL qualify from IDLE if it is still high afterwards.
REQ-022 Each GEIG_EVENT SHALL increment GEIG_COUNT, saturating at 255 with no wrap.
REQ-023 On CNT_CLR, GEIG_COUNT_LATCHED SHALL take the pre-clear GEIG_COUNT and COUNT_VALID SHALL pulse on the next cycle.
REQ-024 On CNT_CLR, GEIG_COUNT SHALL become 0, or 1 if GEIG_EVENT coincides; the event SHALL count in the new window only.
REQ-025 CNT_CLR SHALL NOT affect FSM state; CNT_CLR held high for several cycles SHALL be treated as repeated clears.
REQ-026 All counters SHALL be sized by $clog2 of their limit, and all outputs SHALL be registered.

Reset
REQ-027 RESET_N=0 SHALL asynchronously force FSM=IDLE, all counters and synchronisers to 0, GEIG_EVENT=0, GEIG_COUNT=0, GEIG_COUNT_LATCHED=0, COUNT_VALID=0 and GEIG_STUCK=0.
REQ-028 Reset asserted mid-pulse SHALL emit no event after release until a fresh qualification completes from IDLE.

Configuration
REQ-029 With GEIG_STUCK_DETECT_EN defined, a counter SHALL run in HOLD; when it reaches STUCK_CYCLES, GEIG_STUCK SHALL set, and it SHALL clear on the cycle the FSM leaves HOLD.
REQ-030 With GEIG_STUCK_DETECT_EN undefined, GEIG_STUCK SHALL be constant 0 and no stuck counter SHALL be synthesised.

Verification
REQ-031 A 2 us GSTREAM high pulse SHALL give one GEIG_EVENT at edge 51 and GEIG_COUNT=1.
REQ-032 A 0.5 us (24-cycle) glitch SHALL produce no GEIG_EVENT and leave GEIG_COUNT=0.
REQ-033 Two 2 us pulses 50 us apart SHALL count 1; the same pulses 150 us apart SHALL count 2.
REQ-034 300 spaced pulses followed by CNT_CLR SHALL give GEIG_COUNT_LATCHED=255, COUNT_VALID for 1 cycle, then GEIG_COUNT=0.
REQ-035 CNT_CLR coincident with GEIG_EVENT at count 7 SHALL give GEIG_COUNT_LATCHED=7 and GEIG_COUNT=1.
REQ-036 GSTREAM held high for 20 ms with the macro defined SHALL give 1 event and GEIG_STUCK=1 from 10 ms until the fall, then 0; RESET_N pulsed mid-hold SHALL give no further event while GSTREAM stays high.
